// File: rtl/cmd_ram_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : cmd_ram_ctrl
//  Purpose  : Opcode-driven single-port RAM controller with optional address
//             auto-increment, ready/valid read port and sticky range error.
//  Revision : 1.0 - initial parametrised release
// ============================================================================
module cmd_ram_ctrl #(
    parameter  int DATA_W    = 8,
    parameter  int ADDR_W    = 8,
    parameter  int MEM_DEPTH = 256,
    localparam int PAY_W     = (DATA_W > ADDR_W) ? DATA_W : ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [PAY_W+1:0]  din,
    input  logic              rx_valid,
    output logic              rx_ready,
    input  logic              auto_inc,
    output logic [DATA_W-1:0] dout,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              err
);

    localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    localparam logic [1:0] C_OP_W_ADD  = 2'd0;
    localparam logic [1:0] C_OP_W_DATA = 2'd1;
    localparam logic [1:0] C_OP_R_ADD  = 2'd2;
    localparam logic [1:0] C_OP_R_DATA = 2'd3;

    // Compared one bit wider so MEM_DEPTH == 2**ADDR_W is representable.
    localparam logic [ADDR_W:0] C_DEPTH = (ADDR_W+1)'(MEM_DEPTH);
    localparam logic [ADDR_W:0] C_LAST  = (ADDR_W+1)'(MEM_DEPTH - 1);

    logic [DATA_W-1:0] r_mem [MEM_DEPTH];

    logic [ADDR_W-1:0] r_wr_addr;
    logic [ADDR_W-1:0] r_rd_addr;
    logic [DATA_W-1:0] r_dout;
    logic              r_tx_valid;
    logic              r_err;

    logic [1:0]        w_op;
    logic [ADDR_W-1:0] w_pay_addr;
    logic [DATA_W-1:0] w_pay_data;
    logic              w_accept;
    logic              w_wr_ok;
    logic              w_rd_ok;

    // Wraps at the last word; any out-of-range address also wraps to zero.
    function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
        if ({1'b0, a} >= C_LAST) begin
            return '0;
        end
        return a + 1'b1;
    endfunction

    assign w_op       = din[PAY_W+1:PAY_W];
    assign w_pay_addr = din[ADDR_W-1:0];
    assign w_pay_data = din[DATA_W-1:0];

    assign rx_ready = !(r_tx_valid && !tx_ready);
    assign w_accept = rx_valid && rx_ready;
    assign w_wr_ok  = ({1'b0, r_wr_addr} < C_DEPTH);
    assign w_rd_ok  = ({1'b0, r_rd_addr} < C_DEPTH);

    always_ff @(posedge clk) begin
        if (!rst && w_accept && (w_op == C_OP_W_DATA) && w_wr_ok) begin
            r_mem[r_wr_addr[IDX_W-1:0]] <= w_pay_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_addr  <= '0;
            r_rd_addr  <= '0;
            r_dout     <= '0;
            r_tx_valid <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            if (r_tx_valid && tx_ready) begin
                r_tx_valid <= 1'b0;
            end
            if (w_accept) begin
                case (w_op)
                    C_OP_W_ADD: begin
                        r_wr_addr <= w_pay_addr;
                    end
                    C_OP_W_DATA: begin
                        if (!w_wr_ok) begin
                            r_err <= 1'b1;
                        end
                        if (auto_inc) begin
                            r_wr_addr <= next_addr(r_wr_addr);
                        end
                    end
                    C_OP_R_ADD: begin
                        r_rd_addr <= w_pay_addr;
                    end
                    default: begin
                        r_tx_valid <= 1'b1;
                        if (w_rd_ok) begin
                            r_dout <= r_mem[r_rd_addr[IDX_W-1:0]];
                        end else begin
                            r_dout <= '0;
                            r_err  <= 1'b1;
                        end
                        if (auto_inc) begin
                            r_rd_addr <= next_addr(r_rd_addr);
                        end
                    end
                endcase
            end
        end
    end

    assign dout     = r_dout;
    assign tx_valid = r_tx_valid;
    assign err      = r_err;

endmodule
`default_nettype wire
